or_accumulator: RTL and testbench
=================================

OR_ACCUMULATOR -- requirements
Module: or_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data bit width (>=1).
REQ-002 The block SHALL have parameter WINDOW, default 4, giving the number of samples ORed per result (>=2).
REQ-003 The block SHALL have parameter CNT_W, default 3, giving the sample-count width (2^CNT_W > WINDOW).
REQ-004 Port CLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port RSTn, input, 1 bit: the reset, which SHALL be asynchronous and active-low.
REQ-006 Port IN_VALID, input, 1 bit: the upstream sample on IN0 is valid.
REQ-007 Port IN_READY, output, 1 bit: the block can accept a sample this cycle.
REQ-008 Port IN0, input, WIDTH bits: the sample data, typically driven by or_gate OUT0.
REQ-009 Port FLUSH, input, 1 bit: emit a partial result early.
REQ-010 Port OUT_VALID, output, 1 bit: the result on OUT0/SAMPLES/PARTIAL is valid.
REQ-011 Port OUT_READY, input, 1 bit: downstream accepts the result.
REQ-012 Port OUT0, output, WIDTH bits: the bitwise OR of all samples in the window.
REQ-013 Port SAMPLES, output, CNT_W bits: the number of samples contributing to OUT0.
REQ-014 Port PARTIAL, output, 1 bit: the result was produced by FLUSH with fewer than WINDOW samples.

Function
REQ-015 The block SHALL implement two states: ACCUM (collecting samples) and HOLD (presenting a result).
REQ-016 IN_READY SHALL be 1 in ACCUM and 0 in HOLD, driven combinationally from state only.
REQ-017 A sample SHALL be accepted only on a rising edge with IN_VALID=1 and IN_READY=1.
REQ-018 In ACCUM, an accepted sample SHALL update acc <= acc | IN0 and cnt <= cnt+1; acc and cnt SHALL start at 0 for each window.
REQ-019 When the accepted sample makes cnt+1 equal WINDOW, the next state SHALL be HOLD, with OUT0=acc|IN0, SAMPLES=WINDOW, PARTIAL=0 and OUT_VALID=1.
REQ-020 OUT_VALID SHALL rise exactly one cycle after the edge that accepts the final sample, so latency from final sample to result is 1 cycle.
REQ-021 In ACCUM, FLUSH=1 with cnt>0 or with a sample accepted on the same edge SHALL cause HOLD on the next cycle with PARTIAL=1 and SAMPLES equal to the count including that sample.
REQ-022 FLUSH together with a sample that completes the window SHALL produce PARTIAL=0.
REQ-023 FLUSH with cnt=0 and no accepted sample SHALL be ignored.
REQ-024 FLUSH SHALL be ignored in HOLD.
REQ-025 In HOLD, OUT0, SAMPLES and PARTIAL SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 In HOLD, OUT_READY=1 SHALL return the block to ACCUM on the next edge, with OUT_VALID=0, acc=0 and cnt=0.
REQ-027 No sample SHALL be accepted on the edge that leaves HOLD.
REQ-028 IN0 bits SHALL be ORed per bit with no carries or width changes.
REQ-029 An all-zero window SHALL still produce a result with OUT0=0.
REQ-030 OUT_VALID SHALL be driven from a register, with no combinational path from any input to OUT_VALID, OUT0, SAMPLES or PARTIAL.

Reset
REQ-031 RSTn=0 SHALL immediately force state ACCUM, acc=0, cnt=0, OUT_VALID=0, OUT0=0, SAMPLES=0 and PARTIAL=0, independent of CLK.
REQ-032 Reset asserted mid-window or in HOLD SHALL discard all pending data; after RSTn rises, the first accepted sample SHALL start a new window.
REQ-033 While RSTn=0, IN_READY SHALL read 1, since it is derived from state ACCUM.

Verification
REQ-034 Full window: WIDTH=4, WINDOW=4, samples 0001, 0010, 0000, 1000 accepted on consecutive cycles, OUT_READY=1 -> one cycle later OUT_VALID=1, OUT0=1011, SAMPLES=4, PARTIAL=0; OUT_VALID=0 on the next cycle.
REQ-035 Backpressure: the same window with OUT_READY=0 for 5 cycles, then 1 -> OUT0=1011 held stable, IN_READY=0 throughout HOLD, and IN_VALID samples during HOLD are not absorbed.
REQ-036 Flush: samples 0100 and 0001 accepted, then FLUSH=1 with no sample -> OUT0=0101, SAMPLES=2, PARTIAL=1.
REQ-037 Flush with final sample: 3 samples accepted, then the 4th sample with FLUSH=1 -> SAMPLES=4, PARTIAL=0; FLUSH at cnt=0 produces no OUT_VALID.
REQ-038 Async reset: 2 samples accepted, RSTn pulsed low between clock edges -> all outputs are 0 immediately; the next window of four 0000 samples yields OUT0=0000, SAMPLES=4.
REQ-039 Random soak: random IN_VALID, OUT_READY and FLUSH -> every result equals the reference OR of the accepted samples, and no sample is lost or duplicated.

Source files
------------

// File: rtl/or_accumulator.sv
// ---------------------------------------------------------------------------
// or_accumulator
//   Collects WINDOW valid samples from IN0, ORs them bit by bit and presents
//   the result with a valid/ready handshake. FLUSH ends a window early and
//   marks the result PARTIAL. While a result is presented (HOLD), no new
//   samples are taken.
//
// Parameters
//   WIDTH   data width (>= 1)
//   WINDOW  samples ORed per full result (>= 2)
//   CNT_W   sample counter width (2**CNT_W > WINDOW)
//
// Ports
//   CLK        rising-edge clock
//   RSTn       asynchronous active-low reset
//   IN_VALID   upstream sample on IN0 is valid
//   IN_READY   block accepts a sample this cycle (high in ACCUM)
//   IN0        sample data
//   FLUSH      emit a partial result early
//   OUT_VALID  OUT0/SAMPLES/PARTIAL hold a result
//   OUT_READY  downstream takes the result
//   OUT0       OR of the samples in the window
//   SAMPLES    number of samples that contributed to OUT0
//   PARTIAL    result was cut short by FLUSH
// ---------------------------------------------------------------------------
module or_accumulator #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN0,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT0,
  output logic [CNT_W-1:0] SAMPLES,
  output logic             PARTIAL
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  logic [0:0]       state_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out0_r;
  logic [CNT_W-1:0] samples_r;
  logic             partial_r;

  logic             accept_s;
  logic [WIDTH-1:0] acc_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             full_s;
  logic             flush_s;

  // Ready depends on state alone, so upstream never sees a loop through it.
  assign IN_READY = (state_r == ACCUM);

  // Window arithmetic: what acc/cnt become if this cycle's sample is taken.
  always_comb begin
    accept_s   = IN_VALID & IN_READY;
    if (accept_s) begin
      acc_next_s = acc_r | IN0;
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_next_s = acc_r;
      cnt_next_s = cnt_r;
    end
    // A completing sample wins over FLUSH, so the result is never PARTIAL then.
    full_s  = accept_s && (cnt_next_s == WIN_CNT);
    // FLUSH only matters if at least one sample (old or this one) is present.
    flush_s = FLUSH && (cnt_next_s != {CNT_W{1'b0}});
  end

  // State machine plus registered result outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= ACCUM;
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out0_r      <= {WIDTH{1'b0}};
      samples_r   <= {CNT_W{1'b0}};
      partial_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (full_s || flush_s) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
            out0_r      <= acc_next_s;
            samples_r   <= cnt_next_s;
            partial_r   <= !full_s;
            // The window's contents now live in the result registers.
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
          end
        end
        HOLD: begin
          // IN_READY is low here, so nothing is absorbed on the leaving edge.
          if (OUT_READY) begin
            state_r     <= ACCUM;
            out_valid_r <= 1'b0;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ACCUM;
          out_valid_r <= 1'b0;
          acc_r       <= {WIDTH{1'b0}};
          cnt_r       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign OUT_VALID = out_valid_r;
  assign OUT0      = out0_r;
  assign SAMPLES   = samples_r;
  assign PARTIAL   = partial_r;

endmodule

// File: tb/tb_or_accumulator.sv
// ---------------------------------------------------------------------------
// tb_or_accumulator
//   Directed vector table for or_accumulator (WIDTH=4, WINDOW=4, CNT_W=3),
//   hand-written asynchronous reset sequences and a random soak checked
//   against a reference OR of the accepted samples.
// ---------------------------------------------------------------------------
module tb_or_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in0;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out0;
  logic [2:0] samples;
  logic       partial;

  int n_vec;
  int n_err;

  or_accumulator #(.WIDTH(4), .WINDOW(4), .CNT_W(3)) dut (
    .CLK(clk), .RSTn(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN0(in0),
    .FLUSH(flush),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT0(out0), .SAMPLES(samples), .PARTIAL(partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       f;
    logic       ordy;
    logic       e_ov;
    logic [3:0] e_out0;
    logic [2:0] e_smp;
    logic       e_part;
    logic       e_ir;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic f, input logic ordy);
    in_valid  = v;
    in0       = d;
    flush     = f;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ov"},   {31'd0, out_valid}, 32'd0);
    check({tag, ".out0"}, {28'd0, out0},      32'd0);
    check({tag, ".smp"},  {29'd0, samples},   32'd0);
    check({tag, ".part"}, {31'd0, partial},   32'd0);
    check({tag, ".ir"},   {31'd0, in_ready},  32'd1);
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic f,
                              input logic ordy, input logic e_ov, input logic [3:0] e_out0,
                              input logic [2:0] e_smp, input logic e_part, input logic e_ir);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.ordy = ordy;
    t.e_ov = e_ov; t.e_out0 = e_out0; t.e_smp = e_smp; t.e_part = e_part; t.e_ir = e_ir;
    return t;
  endfunction

  initial begin
    logic [3:0] ref_acc;
    logic [2:0] ref_cnt;
    logic       prev_ov;
    logic [3:0] held_out0;
    logic [2:0] held_smp;
    logic       held_part;
    logic       took;
    int         n_results;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in0 = 4'd0; flush = 1'b0; out_ready = 1'b0;

    // Reset state, checked while reset is still held (IN_READY must read 1).
    #3;
    check_all_zero("reset");
    #9 rst_n = 1'b1;   // t=12, between edges

    //         v     d        f     ordy  e_ov  e_out0   smp   part  ir
    // Full window, downstream always ready.
    tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // Same window under backpressure; samples and FLUSH during HOLD ignored.
    tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1011, 3'd4, 1'b0, 1'b0));
    // Leaving HOLD with a valid sample offered: it must not be absorbed.
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // Flush after two samples (1111 above must not appear).
    tbl.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0101, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // FLUSH with nothing collected is ignored.
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // Three samples, then the fourth with FLUSH: full result, not partial.
    tbl.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0111, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // FLUSH together with the first sample: one-sample partial result.
    tbl.push_back(mk(1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b1000, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    // Idle cycle between samples, then FLUSH with the second sample.
    tbl.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].ordy);
      check($sformatf("vec%0d.ov", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      check($sformatf("vec%0d.ir", i), {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
      // Result fields are only meaningful while OUT_VALID is high.
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d.out0", i), {28'd0, out0},    {28'd0, tbl[i].e_out0});
        check($sformatf("vec%0d.smp", i),  {29'd0, samples}, {29'd0, tbl[i].e_smp});
        check($sformatf("vec%0d.part", i), {31'd0, partial}, {31'd0, tbl[i].e_part});
      end
    end

    // Asynchronous reset while a result is held: outputs clear without a clock.
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check("hold_before_rst.ov", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_hold");
    #1 rst_n = 1'b1;

    // Reset mid-window: the two pending samples must be discarded.
    step(1'b1, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 4'b0110, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("post_rst.ov",   {31'd0, out_valid}, 32'd1);
    check("post_rst.out0", {28'd0, out0},      32'd0);
    check("post_rst.smp",  {29'd0, samples},   32'd4);
    check("post_rst.part", {31'd0, partial},   32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    // Random soak against a reference OR of accepted samples.
    ref_acc = 4'd0; ref_cnt = 3'd0; prev_ov = out_valid;
    held_out0 = 4'd0; held_smp = 3'd0; held_part = 1'b0;
    n_results = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in0       = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 99) < 12);
      out_ready = ($urandom_range(0, 99) < 50);
      took      = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        ref_acc = ref_acc | in0;
        ref_cnt = ref_cnt + 3'd1;
      end
      if (out_valid && !prev_ov) begin
        n_results++;
        check("soak.out0", {28'd0, out0},    {28'd0, ref_acc});
        check("soak.smp",  {29'd0, samples}, {29'd0, ref_cnt});
        check("soak.part", {31'd0, partial}, {31'd0, (ref_cnt != 3'd4)});
        held_out0 = out0; held_smp = samples; held_part = partial;
        ref_acc = 4'd0; ref_cnt = 3'd0;
      end else if (out_valid) begin
        check("soak.hold", {24'd0, out0, samples, partial}, {24'd0, held_out0, held_smp, held_part});
      end
      if (ref_cnt > 3'd4) begin
        n_vec++;
        n_err++;
        $display("FAIL soak.overrun: %0d pending samples, limit 4", ref_cnt);
        ref_cnt = 3'd0;
      end
      prev_ov = out_valid;
    end
    if (n_results < 50) begin
      n_vec++;
      n_err++;
      $display("FAIL soak.results: got %0d results, expected at least 50", n_results);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
